// File: rtl/l1_instruction_cache_if.sv
// l1_instruction_cache_if
//   Groups the predictor-facing request/response signals and the next-level
//   memory miss/fill signals of the L1 instruction cache.
//
//   Handshake semantics (all signals sampled on the rising clock edge):
//     bp_req_valid   single-cycle pulse; never back-pressured. l1i_ready is
//                    advisory only: requests arriving while it is low are held
//                    in a one-entry, newest-wins pending slot.
//     l1i_valid      single-cycle response pulse; the predictor cannot stall it.
//     mem_req_*      valid/ready: mem_req_valid stays high and mem_req_addr
//                    stays stable until a cycle with mem_req_ready high. That
//                    cycle is the transfer.
//     mem_resp_valid single-cycle fill pulse carrying mem_resp_data. It is only
//                    meaningful while a miss is waiting for its fill.
//
//   Modports: slave  = the cache (responder to the predictor)
//             master = the predictor/memory side (testbench)
interface l1_instruction_cache_if #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int PC_SIZE         = 64
);
  logic                         bp_req_valid;
  logic [PC_SIZE-1:0]           bp_req_addr;
  logic                         invalidate_all;
  logic                         l1i_ready;
  logic                         l1i_valid;
  logic [LINE_SIZE_BYTES*8-1:0] l1i_cacheline;
  logic [PC_SIZE-1:0]           l1i_resp_addr;
  logic                         mem_req_valid;
  logic [PC_SIZE-1:0]           mem_req_addr;
  logic                         mem_req_ready;
  logic                         mem_resp_valid;
  logic [LINE_SIZE_BYTES*8-1:0] mem_resp_data;

  modport slave (
    input  bp_req_valid, bp_req_addr, invalidate_all,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output l1i_ready, l1i_valid, l1i_cacheline, l1i_resp_addr,
    output mem_req_valid, mem_req_addr
  );

  modport master (
    output bp_req_valid, bp_req_addr, invalidate_all,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  l1i_ready, l1i_valid, l1i_cacheline, l1i_resp_addr,
    input  mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/l1_instruction_cache.sv
// l1_instruction_cache
//   Direct-mapped L1 instruction cache. A hit is answered with the full line
//   one cycle after the request. A miss fetches the line from the next level,
//   writes it into the array and then answers. Requests that arrive while a
//   miss is outstanding go into a single newest-wins pending slot.
//
// Ports:
//   clk_in     clock
//   rst_N_in   asynchronous active-low reset
//   bus        l1_instruction_cache_if.slave (predictor request/response and
//              next-level miss/fill signals)
//   dbg_state  current FSM state (0 IDLE, 1 MISS_REQ, 2 MISS_WAIT)
module l1_instruction_cache #(
  parameter int SETS            = 64,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int PC_SIZE         = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_N_in,
  l1_instruction_cache_if.slave   bus,
  output logic [1:0]              dbg_state
);
  localparam int OFF    = $clog2(LINE_SIZE_BYTES);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG    = PC_SIZE - IDX - OFF;
  localparam int LINE_W = LINE_SIZE_BYTES * 8;
  localparam int LA_W   = PC_SIZE - OFF;   // line-address width (offset dropped)

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MISS_REQ  = 2'd1,
    S_MISS_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Storage: only the valid bits need a reset value.
  logic [SETS-1:0]   valid_q;
  logic [TAG-1:0]    tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  // Pending slot and outstanding miss. Both hold line addresses only.
  logic              pend_valid_q;
  logic [LA_W-1:0]   pend_line_q;
  logic [LA_W-1:0]   miss_line_q;

  // Registered response.
  logic              l1i_valid_q;
  logic [LINE_W-1:0] l1i_cacheline_q;
  logic [PC_SIZE-1:0] l1i_resp_addr_q;

  // The request serviced in IDLE: a live request beats the pending slot.
  logic              svc_valid;
  logic [LA_W-1:0]   svc_line;
  logic [IDX-1:0]    svc_idx;
  logic [TAG-1:0]    svc_tag;
  logic              svc_hit;
  logic [IDX-1:0]    miss_idx;
  logic [TAG-1:0]    miss_tag;
  logic              fill_we;

  // The byte offset within a line does not affect the lookup.
  logic unused_offset_bits;
  assign unused_offset_bits = ^bus.bp_req_addr[OFF-1:0];

  assign svc_valid = bus.bp_req_valid | pend_valid_q;
  assign svc_line  = bus.bp_req_valid ? bus.bp_req_addr[PC_SIZE-1:OFF] : pend_line_q;
  assign svc_idx   = svc_line[IDX-1:0];
  assign svc_tag   = svc_line[LA_W-1:IDX];
  assign svc_hit   = valid_q[svc_idx] && (tag_q[svc_idx] == svc_tag);
  assign miss_idx  = miss_line_q[IDX-1:0];
  assign miss_tag  = miss_line_q[LA_W-1:IDX];

  // Next state and state-decoded outputs.
  always_comb begin
    state_d           = state_q;
    bus.mem_req_valid = 1'b0;
    bus.l1i_ready     = 1'b0;
    fill_we           = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.l1i_ready = !pend_valid_q;
        if (svc_valid && !svc_hit) state_d = S_MISS_REQ;
      end
      S_MISS_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (bus.mem_resp_valid) begin
          fill_we = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Control and response datapath.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      valid_q         <= '0;
      pend_valid_q    <= 1'b0;
      pend_line_q     <= '0;
      miss_line_q     <= '0;
      l1i_valid_q     <= 1'b0;
      l1i_cacheline_q <= '0;
      l1i_resp_addr_q <= '0;
    end else begin
      l1i_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (svc_valid) begin
            // The slot is consumed, or superseded by the live request.
            pend_valid_q <= 1'b0;
            if (svc_hit) begin
              l1i_valid_q     <= 1'b1;
              l1i_cacheline_q <= data_q[svc_idx];
              l1i_resp_addr_q <= {svc_line, {OFF{1'b0}}};
            end else begin
              miss_line_q <= svc_line;
            end
          end
        end
        S_MISS_REQ, S_MISS_WAIT: begin
          if (bus.bp_req_valid) begin
            pend_valid_q <= 1'b1;
            pend_line_q  <= bus.bp_req_addr[PC_SIZE-1:OFF];
          end
        end
        default: ;
      endcase
      // The fill is always answered, even if the predictor has moved on.
      if (fill_we) begin
        valid_q[miss_idx] <= 1'b1;
        l1i_valid_q       <= 1'b1;
        l1i_cacheline_q   <= bus.mem_resp_data;
        l1i_resp_addr_q   <= {miss_line_q, {OFF{1'b0}}};
      end
      // Placed last so that it overrides a fill writing the same cycle.
      if (bus.invalidate_all) valid_q <= '0;
    end
  end

  // Tag and data arrays: no reset, because valid_q gates every use.
  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= bus.mem_resp_data;
    end
  end

  assign bus.l1i_valid     = l1i_valid_q;
  assign bus.l1i_cacheline = l1i_cacheline_q;
  assign bus.l1i_resp_addr = l1i_resp_addr_q;
  assign bus.mem_req_addr  = {miss_line_q, {OFF{1'b0}}};
  assign dbg_state         = state_q;
endmodule
